// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous word-addressed RAM port between the CPU
// (port 0) and a debug/loader master (port 1). Round-robin arbitration with a
// bounded-burst ownership lock; read data returns one cycle after the grant.
module mem_arbiter #(
  parameter int unsigned MAX_BURST   = 4,
  parameter bit          FIRST_OWNER = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [29:0] addr0,
  input  logic [31:0] wdata0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [29:0] addr1,
  input  logic [31:0] wdata1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [31:0] rdata1,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  logic       owner_q, owner_d;
  logic [3:0] burst_q, burst_d;
  logic       rtag_valid_q, rtag_valid_d;
  logic       rtag_port_q, rtag_port_d;

  logic       pickPort1;
  logic       grantAny;
  logic       selWe;

  // Grant decision. A zero burst count means the previous cycle was idle (or
  // we are just out of reset), which hands a contested cycle to the non-owner.
  // Grants are suppressed while reset is held so no access leaks out.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    pickPort1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        if (burst_q == 4'd0 || burst_q >= MaxBurst) begin
          pickPort1 = ~owner_q;
        end else begin
          pickPort1 = owner_q;
        end
        gnt0 = ~pickPort1;
        gnt1 = pickPort1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Steer the granted port's request fields onto the RAM port.
  always_comb begin
    grantAny  = gnt0 | gnt1;
    selWe     = gnt1 ? we1 : we0;
    mem_addr  = gnt1 ? addr1 : addr0;
    mem_wdata = gnt1 ? wdata1 : wdata0;
    mem_re    = grantAny & ~selWe;
    mem_we    = grantAny & selWe;
  end

  // Next-state: burst counter, ownership and outstanding-read tag.
  always_comb begin
    owner_d      = owner_q;
    burst_d      = burst_q;
    rtag_valid_d = mem_re;
    rtag_port_d  = gnt1;
    if (grantAny) begin
      if ((gnt1 == owner_q) && (burst_q != 4'd0)) begin
        burst_d = (burst_q == 4'd15) ? 4'd15 : burst_q + 4'd1;
      end else begin
        owner_d = gnt1;
        burst_d = 4'd1;
      end
    end else begin
      burst_d = 4'd0;
    end
  end

  // State register; reset drops any outstanding read and primes ownership so
  // the first contested cycle goes to FIRST_OWNER.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q      <= ~FIRST_OWNER;
      burst_q      <= 4'd0;
      rtag_valid_q <= 1'b0;
      rtag_port_q  <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      burst_q      <= burst_d;
      rtag_valid_q <= rtag_valid_d;
      rtag_port_q  <= rtag_port_d;
    end
  end

  // Route returning read data to the port that issued the read.
  always_comb begin
    rvalid0 = rtag_valid_q & ~rtag_port_q;
    rvalid1 = rtag_valid_q & rtag_port_q;
    rdata0  = rvalid0 ? mem_rdata : 32'd0;
    rdata1  = rvalid1 ? mem_rdata : 32'd0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus a randomized run, all
// checked against a transaction-level model of the arbitration rules and RAM.
module tb_mem_arbiter;

  localparam int MAX_BURST   = 4;
  localparam bit FIRST_OWNER = 1'b0;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [29:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_re, mem_we;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.MAX_BURST(MAX_BURST), .FIRST_OWNER(FIRST_OWNER)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Behavioural synchronous RAM; returns junk when not reading so that
  // unqualified read data is visible.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr[7:0]];
    else        mem_rdata <= $urandom;
  end

  // Reference model: last granted port, length of the current unbroken
  // grant run for that port (0 after an idle cycle), pending read, memory.
  int          mLastG;
  int          mStreak;
  bit          mPendValid;
  int          mPendPort;
  logic [31:0] mPendData;
  logic [31:0] modelMem [256];

  task automatic modelReset();
    mLastG     = 1 - int'(FIRST_OWNER);
    mStreak    = 0;
    mPendValid = 1'b0;
    mPendPort  = 0;
  endtask

  // Port the rules award this cycle, or -1 when nobody is granted.
  function automatic int modelPick(input bit r0, input bit r1);
    if (reset)     return -1;
    if (!r0 && !r1) return -1;
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    if (mStreak == 0 || mStreak >= MAX_BURST) return 1 - mLastG;
    return mLastG;
  endfunction

  task automatic modelStep();
    int p;
    bit w;
    logic [29:0] a;
    logic [31:0] d;
    if (reset) begin
      modelReset();
      return;
    end
    p = modelPick(req0, req1);
    mPendValid = 1'b0;
    if (p < 0) begin
      mStreak = 0;
    end else begin
      w = (p == 1) ? we1 : we0;
      a = (p == 1) ? addr1 : addr0;
      d = (p == 1) ? wdata1 : wdata0;
      if (w) begin
        modelMem[a[7:0]] = d;
      end else begin
        mPendValid = 1'b1;
        mPendPort  = p;
        mPendData  = modelMem[a[7:0]];
      end
      if (p == mLastG && mStreak > 0) begin
        mStreak = (mStreak >= 15) ? 15 : mStreak + 1;
      end else begin
        mLastG  = p;
        mStreak = 1;
      end
    end
  endtask

  task automatic driveInputs(input bit r,
                             input bit r0, input bit w0, input logic [29:0] a0, input logic [31:0] d0,
                             input bit r1, input bit w1, input logic [29:0] a1, input logic [31:0] d1);
    @(negedge clk);
    reset = r;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    if (r) modelReset();
  endtask

  task automatic advance();
    modelStep();
    @(posedge clk);
  endtask

  task automatic applyReset();
    driveInputs(1'b1, 0, 0, 30'd0, 32'd0, 0, 0, 30'd0, 32'd0);
    advance();
    driveInputs(1'b0, 0, 0, 30'd0, 32'd0, 0, 0, 30'd0, 32'd0);
    advance();
  endtask

  // Outputs held at zero while reset is asserted, even with both requesting.
  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      driveInputs(1'b1, 1, 0, 30'h10, 32'd1, 1, 1, 30'h20, 32'd2);
      total++;
      if ({gnt0, gnt1, mem_re, mem_we, rvalid0, rvalid1} !== 6'b0) begin
        bad++;
        $display("[TB] FAIL reset_ctrl: got %b want 000000", {gnt0, gnt1, mem_re, mem_we, rvalid0, rvalid1});
      end
      total++;
      if (rdata0 !== 32'd0 || rdata1 !== 32'd0) begin
        bad++;
        $display("[TB] FAIL reset_rdata: got %h/%h want 0/0", rdata0, rdata1);
      end
      advance();
    end
    driveInputs(1'b0, 0, 0, 30'd0, 32'd0, 0, 0, 30'd0, 32'd0);
    advance();
  endtask

  // Lone port 0 read: same-cycle issue, data one cycle later.
  task automatic test_single_read();
    driveInputs(1'b0, 1, 0, 30'h10, 32'd0, 0, 0, 30'd0, 32'd0);
    total++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 30'h10) begin
      bad++;
      $display("[TB] FAIL single_issue: gnt0=%b gnt1=%b re=%b we=%b addr=%h want 1 0 1 0 010", gnt0, gnt1, mem_re, mem_we, mem_addr);
    end
    advance();
    driveInputs(1'b0, 0, 0, 30'd0, 32'd0, 0, 0, 30'd0, 32'd0);
    total++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF || rvalid1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_return: rvalid0=%b rdata0=%h rvalid1=%b want 1 deadbeef 0", rvalid0, rdata0, rvalid1);
    end
    advance();
  endtask

  // Both ports hold requests: port 0 reads, port 1 writes; four-beat bursts.
  task automatic test_burst_pattern();
    bit expPort1;
    for (int i = 0; i < 16; i++) begin
      expPort1 = ((i / MAX_BURST) % 2) == 1;
      driveInputs(1'b0, 1, 0, 30'h30, 32'd0, 1, 1, 30'h50, 32'hA000_0000 + i);
      total++;
      if (gnt0 !== !expPort1 || gnt1 !== expPort1) begin
        bad++;
        $display("[TB] FAIL burst_grant[%0d]: gnt0=%b gnt1=%b want %b %b", i, gnt0, gnt1, !expPort1, expPort1);
      end
      total++;
      if (mem_re !== !expPort1 || mem_we !== expPort1) begin
        bad++;
        $display("[TB] FAIL burst_rw[%0d]: re=%b we=%b want %b %b", i, mem_re, mem_we, !expPort1, expPort1);
      end
      advance();
    end
    driveInputs(1'b0, 0, 0, 30'd0, 32'd0, 0, 0, 30'd0, 32'd0);
    advance();
  endtask

  // Port 1 writes a word that port 0 then reads back.
  task automatic test_write_then_read();
    driveInputs(1'b0, 0, 0, 30'd0, 32'd0, 1, 1, 30'h20, 32'h12345678);
    total++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_we !== 1'b1 || mem_re !== 1'b0 ||
        mem_wdata !== 32'h12345678 || mem_addr !== 30'h20) begin
      bad++;
      $display("[TB] FAIL wr_issue: gnt1=%b we=%b re=%b addr=%h wdata=%h want 1 1 0 020 12345678", gnt1, mem_we, mem_re, mem_addr, mem_wdata);
    end
    advance();
    driveInputs(1'b0, 1, 0, 30'h20, 32'd0, 0, 0, 30'd0, 32'd0);
    total++;
    if (gnt0 !== 1'b1 || mem_re !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rd_issue: gnt0=%b re=%b want 1 1", gnt0, mem_re);
    end
    advance();
    driveInputs(1'b0, 0, 0, 30'd0, 32'd0, 0, 0, 30'd0, 32'd0);
    total++;
    if (rvalid0 !== 1'b1 || rdata0 !== 32'h12345678) begin
      bad++;
      $display("[TB] FAIL wr_readback: rvalid0=%b rdata0=%h want 1 12345678", rvalid0, rdata0);
    end
    advance();
  endtask

  // Port 0 read then port 1 read on consecutive cycles; no cross-routing.
  task automatic test_alternating();
    driveInputs(1'b0, 1, 0, 30'h10, 32'd0, 0, 0, 30'd0, 32'd0);
    advance();
    driveInputs(1'b0, 0, 0, 30'd0, 32'd0, 1, 0, 30'h20, 32'd0);
    total++;
    if (gnt1 !== 1'b1 || rvalid0 !== 1'b1 || rdata0 !== 32'hDEADBEEF || rvalid1 !== 1'b0 || rdata1 !== 32'd0) begin
      bad++;
      $display("[TB] FAIL alt_n1: gnt1=%b rvalid0=%b rdata0=%h rvalid1=%b rdata1=%h want 1 1 deadbeef 0 0", gnt1, rvalid0, rdata0, rvalid1, rdata1);
    end
    advance();
    driveInputs(1'b0, 0, 0, 30'd0, 32'd0, 0, 0, 30'd0, 32'd0);
    total++;
    if (rvalid1 !== 1'b1 || rdata1 !== 32'h12345678 || rvalid0 !== 1'b0 || rdata0 !== 32'd0) begin
      bad++;
      $display("[TB] FAIL alt_n2: rvalid1=%b rdata1=%h rvalid0=%b rdata0=%h want 1 12345678 0 0", rvalid1, rdata1, rvalid0, rdata0);
    end
    advance();
  endtask

  // Reset right after a read grant discards the read; afterwards the first
  // contested cycle belongs to FIRST_OWNER.
  task automatic test_reset_mid_read();
    driveInputs(1'b0, 1, 0, 30'h10, 32'd0, 0, 0, 30'd0, 32'd0);
    total++;
    if (gnt0 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rst_mid_grant: gnt0=%b want 1", gnt0);
    end
    advance();
    driveInputs(1'b1, 1, 0, 30'h10, 32'd0, 1, 1, 30'h20, 32'd5);
    total++;
    if ({gnt0, gnt1, mem_re, mem_we, rvalid0, rvalid1} !== 6'b0 || rdata0 !== 32'd0) begin
      bad++;
      $display("[TB] FAIL rst_mid_outputs: got %b rdata0=%h want 000000 0", {gnt0, gnt1, mem_re, mem_we, rvalid0, rvalid1}, rdata0);
    end
    advance();
    driveInputs(1'b0, 1, 0, 30'h10, 32'd0, 1, 0, 30'h20, 32'd0);
    total++;
    if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_mid_discard: rvalid0=%b rvalid1=%b want 0 0", rvalid0, rvalid1);
    end
    total++;
    if (gnt0 !== !FIRST_OWNER || gnt1 !== FIRST_OWNER) begin
      bad++;
      $display("[TB] FAIL rst_first_owner: gnt0=%b gnt1=%b want %b %b", gnt0, gnt1, !FIRST_OWNER, FIRST_OWNER);
    end
    advance();
    driveInputs(1'b0, 0, 0, 30'd0, 32'd0, 0, 0, 30'd0, 32'd0);
    advance();
  endtask

  // Port 1 raises and withdraws its request mid port-0 burst.
  task automatic test_withdraw();
    bit r1;
    for (int i = 0; i < 6; i++) begin
      r1 = (i == 2);
      if (i < 5) driveInputs(1'b0, 1, 0, 30'h10 + i, 32'd0, r1, 0, 30'h20, 32'd0);
      else       driveInputs(1'b0, 0, 0, 30'd0, 32'd0, 0, 0, 30'd0, 32'd0);
      total++;
      if (gnt0 !== (i < 5) || gnt1 !== 1'b0 || rvalid1 !== 1'b0) begin
        bad++;
        $display("[TB] FAIL withdraw[%0d]: gnt0=%b gnt1=%b rvalid1=%b want %b 0 0", i, gnt0, gnt1, rvalid1, (i < 5));
      end
      if (i > 0) begin
        total++;
        if (rvalid0 !== 1'b1 || rdata0 !== mPendData) begin
          bad++;
          $display("[TB] FAIL withdraw_rd[%0d]: rvalid0=%b rdata0=%h want 1 %h", i, rvalid0, rdata0, mPendData);
        end
      end
      advance();
    end
  endtask

  // Random traffic obeying the hold-until-granted rule (with occasional
  // withdrawals), every cycle checked against the model.
  task automatic test_random();
    int p;
    bit hold0, hold1, expWe;
    logic [29:0] expAddr;
    logic [31:0] expData;
    bit nr0, nw0, nr1, nw1;
    logic [29:0] na0, na1;
    logic [31:0] nd0, nd1;
    hold0 = 0; hold1 = 0;
    for (int c = 0; c < 400; c++) begin
      if (hold0 && $urandom_range(0, 7) != 0) begin
        nr0 = 1; nw0 = we0; na0 = addr0; nd0 = wdata0;
      end else begin
        nr0 = $urandom_range(0, 3) != 0; nw0 = $urandom_range(0, 1) == 1;
        na0 = 30'($urandom_range(0, 31)); nd0 = $urandom;
      end
      if (hold1 && $urandom_range(0, 7) != 0) begin
        nr1 = 1; nw1 = we1; na1 = addr1; nd1 = wdata1;
      end else begin
        nr1 = $urandom_range(0, 3) != 0; nw1 = $urandom_range(0, 1) == 1;
        na1 = 30'($urandom_range(0, 31)); nd1 = $urandom;
      end
      driveInputs(1'b0, nr0, nw0, na0, nd0, nr1, nw1, na1, nd1);
      p = modelPick(req0, req1);
      total++;
      if (gnt0 !== (p == 0) || gnt1 !== (p == 1)) begin
        bad++;
        $display("[TB] FAIL rnd_grant[%0d]: gnt0=%b gnt1=%b want port %0d", c, gnt0, gnt1, p);
      end
      if (p >= 0) begin
        expWe   = (p == 1) ? we1 : we0;
        expAddr = (p == 1) ? addr1 : addr0;
        expData = (p == 1) ? wdata1 : wdata0;
        total++;
        if (mem_we !== expWe || mem_re !== !expWe || mem_addr !== expAddr || (expWe && mem_wdata !== expData)) begin
          bad++;
          $display("[TB] FAIL rnd_issue[%0d]: we=%b re=%b addr=%h wdata=%h want %b %b %h %h", c, mem_we, mem_re, mem_addr, mem_wdata, expWe, !expWe, expAddr, expData);
        end
      end else begin
        total++;
        if (mem_we !== 1'b0 || mem_re !== 1'b0) begin
          bad++;
          $display("[TB] FAIL rnd_idle[%0d]: we=%b re=%b want 0 0", c, mem_we, mem_re);
        end
      end
      total++;
      if (rvalid0 !== (mPendValid && mPendPort == 0) || rvalid1 !== (mPendValid && mPendPort == 1) ||
          rdata0 !== ((mPendValid && mPendPort == 0) ? mPendData : 32'd0) ||
          rdata1 !== ((mPendValid && mPendPort == 1) ? mPendData : 32'd0)) begin
        bad++;
        $display("[TB] FAIL rnd_return[%0d]: rv0=%b rd0=%h rv1=%b rd1=%h want valid=%b port=%0d data=%h", c, rvalid0, rdata0, rvalid1, rdata1, mPendValid, mPendPort, mPendData);
      end
      hold0 = req0 && (p != 0);
      hold1 = req1 && (p != 1);
      advance();
    end
  endtask

  // RAM and model memory start identical.
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]      <= (i == 16) ? 32'hDEADBEEF : 32'hC0DE_0000 + i;
      modelMem[i]  = (i == 16) ? 32'hDEADBEEF : 32'hC0DE_0000 + i;
    end
  end

  // Scenario sequence.
  initial begin
    reset = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    modelReset();
    test_reset();
    test_single_read();
    applyReset();
    test_burst_pattern();
    test_write_then_read();
    test_alternating();
    test_reset_mid_read();
    test_withdraw();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the run stalls.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit, want completion");
    $fatal(1);
  end

endmodule
